// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register-file target.
// Contents:
//   ST_*      FSM state encodings (legacy-compatible localparams).
//   RW_*      R/W bit values carried in the address byte LSB.
//   addr_hit  compares a received address byte with the 7-bit bus address.
package i2c_pkg;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_ADDR     = 4'd1;
  localparam logic [3:0] ST_ACK_ADDR = 4'd2;
  localparam logic [3:0] ST_SUB      = 4'd3;
  localparam logic [3:0] ST_ACK_SUB  = 4'd4;
  localparam logic [3:0] ST_WDATA    = 4'd5;
  localparam logic [3:0] ST_ACK_DATA = 4'd6;
  localparam logic [3:0] ST_TX       = 4'd7;
  localparam logic [3:0] ST_MACK     = 4'd8;
  localparam logic [3:0] ST_IGNORE   = 4'd9;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  function automatic logic addr_hit(input logic [7:0] rx, input logic [6:0] own);
    return rx[7:1] == own;
  endfunction

endpackage

// File: rtl/i2c_in_filter.sv
// Input conditioning for one I2C line: 2-FF synchronizer followed by a
// stability filter. A new level is accepted only after it has been seen for
// FILTER_LEN consecutive CLK cycles; rise/fall pulse for one cycle with it.
// Ports:
//   clk    system clock
//   reset  synchronous active-high reset (line assumed idle high)
//   raw    asynchronous bus line
//   level  filtered level
//   rise   one-cycle pulse when level goes 0->1
//   fall   one-cycle pulse when level goes 1->0
module i2c_in_filter #(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync  <= 2'b11;
      level <= 1'b1;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      rise <= 1'b0;
      fall <= 1'b0;
      // Any return to the current level restarts the stability count.
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(FILTER_LEN - 1)) begin
        level <= sync[1];
        rise  <= sync[1];
        fall  <= ~sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_slave.sv
// I2C target exposing an 8-bit register-file port to the core.
// Transactions: write = START, ADDR+W, SUB, DATA..., STOP;
//               read  = START, ADDR+W, SUB, Sr, ADDR+R, DATA..., STOP.
// Build option: define I2C_SLAVE_AUTOINC_EN to advance REG_ADDR after each
// ACKed write byte and each host-ACKed read byte (burst access).
// Ports:
//   CLK        system clock (>= 20x SCL)
//   RESET      synchronous active-high reset
//   I2C_SCL    bus clock, observed only, never driven
//   I2C_SDA    bus data, driven low or released
//   REG_ADDR   current sub-address
//   REG_WDATA  last received data byte
//   REG_WE     one-cycle write strobe
//   REG_RD     one-cycle read strobe; REG_RDATA sampled 2 CLK later
//   REG_RDATA  read data from the core
//   BUSY       high from an addressed START until STOP
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR = 7'h50,
  parameter int unsigned FILTER_LEN = 3,
  parameter int unsigned SDA_HOLD   = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  inout  wire        I2C_SCL,
  inout  wire        I2C_SDA,
  output logic [7:0] REG_ADDR,
  output logic [7:0] REG_WDATA,
  output logic       REG_WE,
  output logic       REG_RD,
  input  logic [7:0] REG_RDATA,
  output logic       BUSY
);

  localparam int unsigned HOLD_W = $clog2(SDA_HOLD + 1);

  logic scl_f, scl_rise, scl_fall;
  logic sda_f, sda_rise, sda_fall;

  i2c_in_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk   (CLK),
    .reset (RESET),
    .raw   (I2C_SCL),
    .level (scl_f),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_in_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk   (CLK),
    .reset (RESET),
    .raw   (I2C_SDA),
    .level (sda_f),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  logic [3:0]        state;
  logic [2:0]        bit_cnt;
  logic [7:0]        rx_shift;
  logic [7:0]        tx_shift;
  logic              rw;
  logic              sda_low;   // 1 = pulling SDA low
  logic              sda_pend;  // value to apply when the hold timer expires
  logic [HOLD_W-1:0] hold_cnt;
  logic [1:0]        rd_wait;

  logic       start_cond, stop_cond;
  logic [7:0] rx_byte;
  logic       drive_val;
  logic [7:0] addr_adv;

  assign start_cond = sda_fall & scl_f;
  assign stop_cond  = sda_rise & scl_f;
  assign rx_byte    = {rx_shift[6:0], sda_f};

`ifdef I2C_SLAVE_AUTOINC_EN
  assign addr_adv = REG_ADDR + 8'd1;
`else
  assign addr_adv = REG_ADDR;
`endif

  // SDA level wanted for the bit period that starts at this SCL fall.
  always_comb begin
    drive_val = 1'b0;
    case (state)
      ST_ACK_ADDR, ST_ACK_SUB, ST_ACK_DATA: drive_val = 1'b1;
      ST_TX:                                drive_val = ~tx_shift[7];
      default:                              drive_val = 1'b0;
    endcase
  end

  // Reset releases the line combinationally, not one edge later.
  assign I2C_SDA = (sda_low && !RESET) ? 1'b0 : 1'bz;
  assign I2C_SCL = 1'bz;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      rw        <= RW_WRITE;
      sda_low   <= 1'b0;
      sda_pend  <= 1'b0;
      hold_cnt  <= '0;
      rd_wait   <= '0;
      REG_ADDR  <= '0;
      REG_WDATA <= '0;
      REG_WE    <= 1'b0;
      REG_RD    <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      REG_WE <= 1'b0;
      REG_RD <= 1'b0;

      if (rd_wait != 2'd0) begin
        rd_wait <= rd_wait - 2'd1;
        if (rd_wait == 2'd1) tx_shift <= REG_RDATA;
      end

      if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - 1'b1;
        if (hold_cnt == HOLD_W'(1)) sda_low <= sda_pend;
      end

      if (start_cond) begin
        state    <= ST_ADDR;
        bit_cnt  <= '0;
        sda_low  <= 1'b0;
        hold_cnt <= '0;
      end else if (stop_cond) begin
        state    <= ST_IDLE;
        BUSY     <= 1'b0;
        sda_low  <= 1'b0;
        hold_cnt <= '0;
      end else if (scl_rise) begin
        rx_shift <= rx_byte;
        case (state)
          ST_ADDR: begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (addr_hit(rx_byte, SLAVE_ADDR)) begin
                state <= ST_ACK_ADDR;
                rw    <= rx_byte[0];
                BUSY  <= 1'b1;
              end else begin
                state <= ST_IGNORE;
              end
            end
          end
          ST_ACK_ADDR: begin
            bit_cnt <= '0;
            if (rw == RW_READ) begin
              state   <= ST_TX;
              REG_RD  <= 1'b1;
              rd_wait <= 2'd2;
            end else begin
              state <= ST_SUB;
            end
          end
          ST_SUB: begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              REG_ADDR <= rx_byte;
              state    <= ST_ACK_SUB;
            end
          end
          ST_ACK_SUB: begin
            bit_cnt <= '0;
            state   <= ST_WDATA;
          end
          ST_WDATA: begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              REG_WDATA <= rx_byte;
              REG_WE    <= 1'b1;
              state     <= ST_ACK_DATA;
            end
          end
          ST_ACK_DATA: begin
            bit_cnt  <= '0;
            REG_ADDR <= addr_adv;
            state    <= ST_WDATA;
          end
          ST_TX: begin
            bit_cnt  <= bit_cnt + 3'd1;
            tx_shift <= {tx_shift[6:0], 1'b1};
            if (bit_cnt == 3'd7) state <= ST_MACK;
          end
          ST_MACK: begin
            bit_cnt <= '0;
            if (!sda_f) begin
              REG_ADDR <= addr_adv;
              REG_RD   <= 1'b1;
              rd_wait  <= 2'd2;
              state    <= ST_TX;
            end else begin
              state <= ST_IGNORE;
            end
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        sda_pend <= drive_val;
        hold_cnt <= HOLD_W'(SDA_HOLD);
      end
    end
  end

endmodule
